// File: rtl/loopback_call_pkg.sv
// Shared types for the loopback call scheduler: per-requester call state and method ids.
package loopback_call_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } call_state_t;

    localparam logic [7:0] METHOD_INC = 8'd0;

endpackage

// File: rtl/loopback_rr_arb.sv
// Round-robin picker over pending requesters; the grant is frozen while lock is high
// so a stalled engine issue never changes owner.
module loopback_rr_arb #(
    parameter int N_REQ = 4,
    parameter int TAG_W = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic [TAG_W-1:0] ptr,
    input  logic             lock,
    output logic [N_REQ-1:0] grant,
    output logic [TAG_W-1:0] idx
);

    logic             locked_reg;
    logic [TAG_W-1:0] locked_idx_reg;
    logic [N_REQ-1:0] rot;
    logic [TAG_W-1:0] rr_idx;
    logic             rr_any;
    int               sum;

    // rot[k] is the request of requester (ptr+k) mod N_REQ
    always_comb begin
        rot    = N_REQ'({req, req} >> ptr);
        rr_idx = '0;
        rr_any = 1'b0;
        sum    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!rr_any && rot[k]) begin
                rr_any = 1'b1;
                sum    = int'(ptr) + k;
                if (sum >= N_REQ) begin
                    sum = sum - N_REQ;
                end
                rr_idx = TAG_W'(sum);
            end
        end
    end

    always_comb begin
        idx   = locked_reg ? locked_idx_reg : rr_idx;
        grant = (locked_reg || rr_any) ? (N_REQ'(1) << idx) : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            locked_reg     <= 1'b0;
            locked_idx_reg <= '0;
        end else begin
            locked_reg     <= lock;
            locked_idx_reg <= idx;
        end
    end

endmodule

// File: rtl/loopback_call_sched.sv
// Per-requester call FSMs sharing one increment engine; unknown methods are answered locally
// with an error, engine results are routed back by tag.
module loopback_call_sched
    import loopback_call_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*8-1:0]      req_id,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        rsp_valid,
    input  logic [N_REQ-1:0]        rsp_ready,
    output logic [N_REQ*DATA_W-1:0] rsp_data,
    output logic [N_REQ-1:0]        rsp_err,
    output logic                    eng_req_valid,
    input  logic                    eng_req_ready,
    output logic [TAG_W-1:0]        eng_req_tag,
    output logic [DATA_W-1:0]       eng_req_data,
    input  logic                    eng_rsp_valid,
    input  logic [TAG_W-1:0]        eng_rsp_tag,
    input  logic [DATA_W-1:0]       eng_rsp_data,
    output logic [TAG_W:0]          outstanding,
    output logic                    stray_err
);

    localparam int OUT_W = TAG_W + 1;

    logic [N_REQ-1:0]        pend_vec;
    logic [N_REQ-1:0]        busy_vec;
    logic [N_REQ-1:0]        rsp_match;
    logic [N_REQ-1:0]        grant;
    logic [N_REQ*DATA_W-1:0] data_flat;
    logic [TAG_W-1:0]        grant_idx;
    logic [TAG_W-1:0]        rr_ptr_reg, rr_ptr_next;
    logic                    stray_err_reg;
    logic                    issue_hs;

    assign eng_req_valid = |pend_vec;
    assign issue_hs      = eng_req_valid && eng_req_ready;
    assign eng_req_tag   = grant_idx;
    assign rsp_data      = data_flat;
    assign stray_err     = stray_err_reg;

    loopback_rr_arb #(.N_REQ(N_REQ), .TAG_W(TAG_W)) u_arb (
        .clock (clock),
        .reset (reset),
        .req   (pend_vec),
        .ptr   (rr_ptr_reg),
        .lock  (eng_req_valid && !eng_req_ready),
        .grant (grant),
        .idx   (grant_idx)
    );

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
        call_state_t       state_reg, state_next;
        logic [DATA_W-1:0] data_reg, data_next;
        logic              err_reg, err_next;

        assign pend_vec[gi]  = (state_reg == ST_PEND);
        assign busy_vec[gi]  = (state_reg == ST_PEND) || (state_reg == ST_WAIT);
        assign req_ready[gi] = (state_reg == ST_IDLE);
        assign rsp_valid[gi] = (state_reg == ST_HOLD);
        assign rsp_err[gi]   = err_reg;
        assign data_flat[gi*DATA_W +: DATA_W] = data_reg;
        assign rsp_match[gi] = eng_rsp_valid && (eng_rsp_tag == TAG_W'(gi)) && (state_reg == ST_WAIT);

        // data_reg holds the argument until the engine result replaces it
        always_comb begin
            state_next = state_reg;
            data_next  = data_reg;
            err_next   = err_reg;
            unique case (state_reg)
                ST_IDLE: if (req_valid[gi]) begin
                    if (req_id[gi*8 +: 8] == METHOD_INC) begin
                        state_next = ST_PEND;
                        data_next  = req_data[gi*DATA_W +: DATA_W];
                        err_next   = 1'b0;
                    end else begin
                        state_next = ST_HOLD;
                        data_next  = '0;
                        err_next   = 1'b1;
                    end
                end
                ST_PEND: if (issue_hs && grant[gi]) state_next = ST_WAIT;
                ST_WAIT: if (rsp_match[gi]) begin
                    state_next = ST_HOLD;
                    data_next  = eng_rsp_data;
                    err_next   = 1'b0;
                end
                ST_HOLD: if (rsp_ready[gi]) state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                state_reg <= ST_IDLE;
                data_reg  <= '0;
                err_reg   <= 1'b0;
            end else begin
                state_reg <= state_next;
                data_reg  <= data_next;
                err_reg   <= err_next;
            end
        end
    end

    always_comb begin
        eng_req_data = '0;
        outstanding  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                eng_req_data = data_flat[i*DATA_W +: DATA_W];
            end
            outstanding = outstanding + OUT_W'(busy_vec[i]);
        end
    end

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (issue_hs) begin
            rr_ptr_next = (grant_idx == TAG_W'(N_REQ - 1)) ? '0 : grant_idx + TAG_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_reg    <= '0;
            stray_err_reg <= 1'b0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
            if (eng_rsp_valid && !(|rsp_match)) begin
                stray_err_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_loopback_call_sched.sv
// Bench for loopback_call_sched: vector table plus hand sequences, responses checked by a scoreboard.
module tb_loopback_call_sched;
    import loopback_call_pkg::*;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TW = 2;

    logic            clock = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
    logic [N*8-1:0]  req_id;
    logic [N*DW-1:0] req_data, rsp_data;
    logic            eng_req_valid, eng_req_ready, eng_rsp_valid, stray_err;
    logic [TW-1:0]   eng_req_tag, eng_rsp_tag;
    logic [DW-1:0]   eng_req_data, eng_rsp_data;
    logic [TW:0]     outstanding;

    always #5 clock = ~clock;

    loopback_call_sched #(.N_REQ(N), .DATA_W(DW), .TAG_W(TW)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .eng_req_valid(eng_req_valid), .eng_req_ready(eng_req_ready),
        .eng_req_tag(eng_req_tag), .eng_req_data(eng_req_data),
        .eng_rsp_valid(eng_rsp_valid), .eng_rsp_tag(eng_rsp_tag), .eng_rsp_data(eng_rsp_data),
        .outstanding(outstanding), .stray_err(stray_err)
    );

    typedef struct {
        int          r;
        logic [7:0]  id;
        logic [31:0] arg;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    typedef struct {
        int          r;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    vec_t vecs[6];
    rsp_t sb_q[$];
    int   issue_q[$];
    int   checks = 0;
    int   errors = 0;
    int   max_out = 0;
    logic eng_auto;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_pop(input int r);
        int found;
        found = -1;
        for (int k = 0; k < sb_q.size(); k++) begin
            if (found < 0 && sb_q[k].r == r) found = k;
        end
        if (found < 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: requester %0d data %0h, no call outstanding", r, rsp_data[r*DW +: DW]);
        end else begin
            chk($sformatf("rsp_data[%0d]", r), 64'(rsp_data[r*DW +: DW]), 64'(sb_q[found].data));
            chk($sformatf("rsp_err[%0d]", r), 64'(rsp_err[r]), 64'(sb_q[found].err));
            $display("rsp   req=%0d data=%0h err=%0b", r, rsp_data[r*DW +: DW], rsp_err[r]);
            sb_q.delete(found);
        end
    endtask

    // one clock: observe handshakes before the edge, play the engine after it
    task automatic tick();
        logic          hs;
        logic [TW-1:0] t;
        logic [DW-1:0] d;
        #2;
        hs = eng_req_valid && eng_req_ready;
        t  = eng_req_tag;
        d  = eng_req_data;
        if (hs) begin
            issue_q.push_back(int'(t));
            $display("issue tag=%0d data=%0h", t, d);
        end
        if (!reset) begin
            for (int r = 0; r < N; r++) begin
                if (rsp_valid[r] && rsp_ready[r]) sb_pop(r);
            end
        end
        @(posedge clock);
        #1;
        eng_rsp_valid = eng_auto && hs;
        eng_rsp_tag   = t;
        eng_rsp_data  = d + 32'd1;
        if (int'(outstanding) > max_out) max_out = int'(outstanding);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        eng_rsp_valid = 1'b0;
        sb_q.delete();
        issue_q.delete();
    endtask

    task automatic call(input int r, input logic [7:0] id, input logic [31:0] arg,
                        input logic [31:0] exp_data, input logic exp_err);
        rsp_t e;
        req_valid[r]           = 1'b1;
        req_id[r*8 +: 8]       = id;
        req_data[r*DW +: DW]   = arg;
        e.r = r; e.data = exp_data; e.err = exp_err;
        sb_q.push_back(e);
        $display("call  req=%0d id=%0d arg=%0h", r, id, arg);
    endtask

    task automatic wait_drain(input string name);
        for (int c = 0; c < 30 && sb_q.size() != 0; c++) tick();
        chk(name, 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        reset = 1'b1;
        req_valid = '0; req_id = '0; req_data = '0; rsp_ready = '1;
        eng_req_ready = 1'b1; eng_rsp_valid = 1'b0; eng_rsp_tag = '0; eng_rsp_data = '0;
        eng_auto = 1'b1;

        vecs[0] = '{0, 8'd0,   32'd41,         32'd42,   1'b0, 3};
        vecs[1] = '{2, 8'd5,   32'd7,          32'd0,    1'b1, 1};
        vecs[2] = '{1, 8'd0,   32'hFFFF_FFFF,  32'd0,    1'b0, 3};
        vecs[3] = '{3, 8'hFF,  32'd123,        32'd0,    1'b1, 1};
        vecs[4] = '{3, 8'd0,   32'd1000,       32'd1001, 1'b0, 3};
        vecs[5] = '{0, 8'd1,   32'd99,         32'd0,    1'b1, 1};

        tick();
        do_reset();
        chk("rst_req_ready", 64'(req_ready), 64'hF);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_eng_valid", 64'(eng_req_valid), 64'h0);
        chk("rst_outstanding", 64'(outstanding), 64'h0);
        chk("rst_stray", 64'(stray_err), 64'h0);

        // single calls from the table
        for (int v = 0; v < 6; v++) begin
            call(vecs[v].r, vecs[v].id, vecs[v].arg, vecs[v].exp_data, vecs[v].exp_err);
            tick();
            req_valid = '0;
            lat = 1;
            while (!rsp_valid[vecs[v].r] && lat < 10) begin
                tick();
                lat++;
            end
            chk($sformatf("latency_v%0d", v), 64'(lat), 64'(vecs[v].exp_lat));
            if (vecs[v].exp_err) chk($sformatf("no_engine_v%0d", v), 64'(eng_req_valid), 64'h0);
            wait_drain($sformatf("drain_v%0d", v));
        end

        // all four call at once: issue order 0..3, outstanding peaks at 4
        do_reset();
        max_out = 0;
        for (int r = 0; r < N; r++) call(r, 8'd0, 32'(r * 10 + 5), 32'(r * 10 + 6), 1'b0);
        tick();
        req_valid = '0;
        wait_drain("all4_drain");
        chk("all4_issues", 64'(issue_q.size()), 64'd4);
        for (int k = 0; k < issue_q.size() && k < 4; k++) chk($sformatf("all4_tag%0d", k), 64'(issue_q[k]), 64'(k));
        chk("all4_peak", 64'(max_out), 64'd4);

        // engine stall: grant to 1 frozen even after requester 0 becomes pending
        issue_q.delete();
        eng_req_ready = 1'b0;
        call(1, 8'd0, 32'd100, 32'd101, 1'b0);
        call(3, 8'd0, 32'd300, 32'd301, 1'b0);
        tick();
        req_valid = '0;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("stall_valid_c%0d", c), 64'(eng_req_valid), 64'h1);
            chk($sformatf("stall_tag_c%0d", c), 64'(eng_req_tag), 64'd1);
            chk($sformatf("stall_data_c%0d", c), 64'(eng_req_data), 64'd100);
            if (c == 0) call(0, 8'd0, 32'd50, 32'd51, 1'b0);
            tick();
            req_valid = '0;
        end
        eng_req_ready = 1'b1;
        for (int c = 0; c < 10 && issue_q.size() < 3; c++) tick();
        chk("stall_issues", 64'(issue_q.size()), 64'd3);
        if (issue_q.size() >= 3) begin
            chk("stall_first", 64'(issue_q[0]), 64'd1);
            chk("stall_second", 64'(issue_q[1]), 64'd3);
            chk("stall_third", 64'(issue_q[2]), 64'd0);
        end
        wait_drain("stall_drain");

        // result for an idle requester is stray and sticky
        tick();
        chk("stray_pre", 64'(stray_err), 64'h0);
        eng_rsp_valid = 1'b1; eng_rsp_tag = 2'd2; eng_rsp_data = 32'd5;
        tick();
        chk("stray_set", 64'(stray_err), 64'h1);
        chk("stray_no_rsp", 64'(rsp_valid), 64'h0);
        tick(); tick(); tick();
        chk("stray_sticky", 64'(stray_err), 64'h1);
        do_reset();
        chk("stray_cleared", 64'(stray_err), 64'h0);

        // reset while requester 1 waits on the engine
        eng_auto = 1'b0;
        call(1, 8'd0, 32'd77, 32'd78, 1'b0);
        tick();
        req_valid = '0;
        tick();
        chk("wait_outstanding", 64'(outstanding), 64'd1);
        do_reset();
        chk("abort_outstanding", 64'(outstanding), 64'd0);
        chk("abort_req_ready", 64'(req_ready), 64'hF);
        chk("abort_rsp_valid", 64'(rsp_valid), 64'h0);
        eng_rsp_valid = 1'b1; eng_rsp_tag = 2'd1; eng_rsp_data = 32'd78;
        tick();
        chk("late_stray", 64'(stray_err), 64'h1);
        chk("late_no_rsp", 64'(rsp_valid[1]), 64'h0);
        eng_auto = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
